srl_fir_seq: RTL and testbench
==============================

SRL_FIR_SEQ -- requirements
Module: srl_fir_seq

Interface
REQ-001 Parameter NTAPS, default 128, number of delay-line taps swept per sample; legal range 2..128.
REQ-002 clk  input  1  clock; all logic rising-edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_stb  input  1  new input sample strobe, one cycle per sample.
REQ-005 din  input  16  input sample, valid when in_stb=1.
REQ-006 sr_d  output  16  data to delay-line shift register input.
REQ-007 sr_ce  output  1  delay-line shift enable.
REQ-008 sr_a  output  7  delay-line tap address; 0 = newest sample.
REQ-009 sr_y  input  16  delay-line addressed output; combinational from sr_a.
REQ-010 tap  output  16  registered tap data to downstream MAC.
REQ-011 tap_adr  output  7  tap index for tap, used as coefficient address.
REQ-012 tap_vld  output  1  tap and tap_adr valid.
REQ-013 first  output  1  with tap_vld, marks tap index 0 (MAC clears accumulator).
REQ-014 last  output  1  with tap_vld, marks tap index NTAPS-1 (MAC dumps result).
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 ovr  output  1  overrun indicator.
REQ-017 ovr_clr  input  1  clears sticky overrun; ignored unless OVR_STICKY_EN is defined.

Function
REQ-018 The state machine SHALL have states IDLE, LOAD, SWEEP and FLUSH.
REQ-019 in_stb in IDLE or FLUSH SHALL capture din into sr_d and enter LOAD on the next cycle.
REQ-020 LOAD SHALL last exactly one cycle with sr_ce=1; sr_ce SHALL be 0 in every other state.
REQ-021 SWEEP SHALL drive sr_a=k on the k-th SWEEP cycle, k=0..NTAPS-1, then enter FLUSH.
REQ-022 FLUSH SHALL last one cycle, then enter IDLE unless in_stb is accepted (REQ-019).
REQ-023 tap<=sr_y, tap_adr<=sr_a and tap_vld<=1 SHALL be registered one cycle after each SWEEP address.
REQ-024 Timing: for in_stb at cycle t, LOAD occurs at t+1, sr_a=k at t+2+k, tap k valid at t+3+k, and the last tap is valid at t+2+NTAPS.
REQ-025 Throughput: a sample SHALL be accepted every NTAPS+2 cycles when in_stb is asserted in FLUSH.
REQ-026 first SHALL equal tap_vld AND tap_adr==0; last SHALL equal tap_vld AND tap_adr==NTAPS-1.
REQ-027 in_stb in LOAD or SWEEP SHALL be ignored: the sample is dropped, the SRL is not shifted and the sweep continues unchanged.
REQ-028 Without OVR_STICKY_EN, ovr SHALL pulse high for one cycle, one cycle after each ignored in_stb.
REQ-029 The address counter SHALL stop at NTAPS-1 and never wrap within a sweep; sr_a SHALL hold 0 outside SWEEP.

Reset
REQ-030 rst SHALL force state IDLE and set sr_ce, tap_vld, first, last, busy and ovr to 0 and sr_a, sr_d, tap and tap_adr to 0 on the next edge, including mid-sweep.
REQ-031 rst SHALL NOT clear the delay-line contents; no tap_vld is produced for an aborted sweep.
REQ-032 in_stb coincident with rst SHALL be ignored.

Configuration
REQ-033 Macro OVR_STICKY_EN SHALL control overrun reporting.
REQ-034 With OVR_STICKY_EN defined, ovr SHALL set on an ignored in_stb and hold until ovr_clr=1 or rst.
REQ-035 With OVR_STICKY_EN defined, a set and an ovr_clr in the same cycle SHALL leave ovr set.
REQ-036 Without OVR_STICKY_EN, ovr_clr SHALL have no effect and ovr SHALL follow REQ-028.

Verification
REQ-037 NTAPS=4, in_stb din=0x1234 at cycle 0 -> sr_ce=1 at cycle 1; sr_a=0,1,2,3 at cycles 2-5; tap_vld at cycles 3-6 with first at 3 and last at 6; busy for cycles 1-6.
REQ-038 NTAPS=4, samples 0x0001..0x0005 pushed one per sweep -> the fifth sweep emits tap 0x0005, 0x0004, 0x0003, 0x0002 in that order.
REQ-039 NTAPS=128, in_stb in FLUSH -> LOAD on the next cycle; back-to-back sweeps every 130 cycles with no tap_vld gap beyond 2 cycles.
REQ-040 NTAPS=8, in_stb during SWEEP at sr_a=3 -> no sr_ce pulse, sweep completes all 8 taps, ovr pulses once (sticky until ovr_clr when OVR_STICKY_EN is defined).
REQ-041 NTAPS=8, rst at sr_a=5 -> next cycle busy=0, tap_vld=0, sr_a=0; a new in_stb then produces a full 8-tap sweep.

Source files
------------

// File: rtl/srl_fir_seq.sv
`default_nettype none
// ============================================================================
//  Module      : srl_fir_seq
//  Description : Sequencer for a time-multiplexed FIR filter built around an
//                addressable shift-register delay line. Each accepted sample
//                is shifted into the delay line. The NTAPS taps are then swept
//                out one per cycle to a downstream MAC, with first/last
//                framing. Strobes that arrive while a sweep is running are
//                dropped and reported on ovr.
//  Options     : OVR_STICKY_EN - when defined, ovr is sticky until ovr_clr
//                or rst; otherwise ovr is a one-cycle pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module srl_fir_seq #(
    parameter int NTAPS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_stb,
    input  logic [15:0] din,
    output logic [15:0] sr_d,
    output logic        sr_ce,
    output logic [6:0]  sr_a,
    input  logic [15:0] sr_y,
    output logic [15:0] tap,
    output logic [6:0]  tap_adr,
    output logic        tap_vld,
    output logic        first,
    output logic        last,
    output logic        busy,
    output logic        ovr,
    input  logic        ovr_clr
);

    localparam logic [6:0] c_LAST_ADR = 7'(NTAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SWEEP = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        w_ignore;
    logic [6:0]  r_cnt;
    logic        r_ovr;

    // Next-state logic. A sample can be taken in IDLE, or in FLUSH so that
    // sweeps run back to back. A strobe seen in LOAD or SWEEP is dropped.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_ignore = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_stb) begin
                    w_accept = 1'b1;
                    w_next   = S_LOAD;
                end
            end
            S_LOAD: begin
                w_ignore = in_stb;
                w_next   = S_SWEEP;
            end
            S_SWEEP: begin
                w_ignore = in_stb;
                if (r_cnt == c_LAST_ADR) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (in_stb) begin
                    w_accept = 1'b1;
                    w_next   = S_LOAD;
                end else begin
                    w_next   = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State, sample capture, sweep address counter and tap output register.
    // The counter saturates at the last tap. It is cleared outside SWEEP so
    // that every sweep starts at address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 7'd0;
            sr_d    <= 16'd0;
            tap     <= 16'd0;
            tap_adr <= 7'd0;
            tap_vld <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                sr_d <= din;
            end
            if (r_state == S_SWEEP) begin
                if (r_cnt != c_LAST_ADR) begin
                    r_cnt <= r_cnt + 7'd1;
                end
            end else begin
                r_cnt <= 7'd0;
            end
            tap_vld <= (r_state == S_SWEEP);
            if (r_state == S_SWEEP) begin
                tap     <= sr_y;
                tap_adr <= sr_a;
            end
        end
    end

    // Overrun reporting for dropped strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovr <= 1'b0;
        end else begin
`ifdef OVR_STICKY_EN
            r_ovr <= w_ignore | (r_ovr & ~ovr_clr);
`else
            r_ovr <= w_ignore;
`endif
        end
    end

`ifndef OVR_STICKY_EN
    // ovr_clr only matters for the sticky variant.
    logic w_unused_ovr_clr;
    assign w_unused_ovr_clr = ovr_clr;
`endif

    assign sr_ce = (r_state == S_LOAD);
    assign sr_a  = (r_state == S_SWEEP) ? r_cnt : 7'd0;
    assign busy  = (r_state != S_IDLE);
    assign first = tap_vld & (tap_adr == 7'd0);
    assign last  = tap_vld & (tap_adr == c_LAST_ADR);
    assign ovr   = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_srl_fir_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_srl_fir_seq
//  Description : Scoreboard bench for srl_fir_seq with a behavioural delay
//                line and a sample-history reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_srl_fir_seq;

    localparam int N    = 8;
    localparam int MAXC = 4096;

    logic        clk;
    logic        rst;
    logic        in_stb;
    logic [15:0] din;
    logic [15:0] sr_d;
    logic        sr_ce;
    logic [6:0]  sr_a;
    logic [15:0] sr_y;
    logic [15:0] tap;
    logic [6:0]  tap_adr;
    logic        tap_vld;
    logic        first;
    logic        last;
    logic        busy;
    logic        ovr;
    logic        ovr_clr;

    srl_fir_seq #(.NTAPS(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_stb  (in_stb),
        .din     (din),
        .sr_d    (sr_d),
        .sr_ce   (sr_ce),
        .sr_a    (sr_a),
        .sr_y    (sr_y),
        .tap     (tap),
        .tap_adr (tap_adr),
        .tap_vld (tap_vld),
        .first   (first),
        .last    (last),
        .busy    (busy),
        .ovr     (ovr),
        .ovr_clr (ovr_clr)
    );

    // Behavioural addressable shift register (delay line).
    logic [15:0] srl [128];
    always @(posedge clk) begin
        if (sr_ce) begin
            for (int i = 127; i > 0; i--) srl[i] <= srl[i-1];
            srl[0] <= sr_d;
        end
    end
    assign sr_y = srl[sr_a];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] d;
        logic [6:0]  a;
    } tap_t;

    tap_t        q[$];
    logic [15:0] hist[$];
    int          n_chk;
    int          n_pass;
    int          cyc;
    int          last_acc;
    logic        m_ovr;
    bit          exp_ce   [MAXC];
    bit          exp_busy [MAXC];
    bit          exp_ovr  [MAXC];
    logic [6:0]  exp_sra  [MAXC];
    logic [15:0] exp_d    [MAXC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    endtask

    // Reference model: a sample is taken when no sweep is pending, or when
    // the previous one has reached FLUSH (NTAPS+2 cycles later). Tap k shows
    // the k-th newest accepted sample, NTAPS+... cycles laid out as t+3+k.
    task automatic model(input int c, input logic r, input logic s,
                         input logic [15:0] d, input logic cl);
        bit acc;
        bit ign;
        if (r) begin
            for (int i = c + 1; i < MAXC && i <= c + N + 4; i++) begin
                exp_ce[i]   = 1'b0;
                exp_busy[i] = 1'b0;
                exp_ovr[i]  = 1'b0;
                exp_sra[i]  = 7'd0;
            end
            while (q.size() > 0 && q[$].cyc > c) void'(q.pop_back());
            last_acc = -1000;
            m_ovr    = 1'b0;
        end else begin
            acc = s && (c >= last_acc + N + 2);
            ign = s && !acc;
            if (acc) begin
                hist.push_front(d);
                exp_ce[c+1] = 1'b1;
                exp_d[c+1]  = d;
                for (int i = 1; i <= N + 2; i++) exp_busy[c+i] = 1'b1;
                for (int k = 0; k < N; k++) begin
                    exp_sra[c+2+k] = 7'(k);
                    q.push_back('{cyc: c + 3 + k, d: hist[k], a: 7'(k)});
                end
                last_acc = c;
            end
`ifdef OVR_STICKY_EN
            m_ovr = ign | (m_ovr & ~cl);
`else
            m_ovr = ign;
`endif
            exp_ovr[c+1] = m_ovr;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [15:0] d, input logic cl);
        @(posedge clk);
        #1;
        cyc++;
        rst = r; in_stb = s; din = d; ovr_clr = cl;
        model(cyc, r, s, d, cl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    // Monitor: per-cycle control checks and tap scoreboard.
    initial begin
        tap_t e;
        forever begin
            @(negedge clk);
            if (cyc >= 1 && cyc < MAXC) begin
                if (cyc == 1) begin
                    chk("rst_tap", tap, 0);
                    chk("rst_tap_adr", tap_adr, 0);
                    chk("rst_sr_d", sr_d, 0);
                end
                chk("sr_ce", sr_ce, exp_ce[cyc]);
                chk("sr_a", sr_a, exp_sra[cyc]);
                chk("busy", busy, exp_busy[cyc]);
                chk("ovr", ovr, exp_ovr[cyc]);
                if (exp_ce[cyc]) chk("sr_d", sr_d, exp_d[cyc]);
                if (tap_vld) begin
                    if (q.size() == 0) begin
                        chk("tap_spurious", tap_vld, 0);
                    end else begin
                        e = q.pop_front();
                        chk("tap_cycle", cyc, e.cyc);
                        chk("tap", tap, e.d);
                        chk("tap_adr", tap_adr, e.a);
                        chk("first", first, (e.a == 7'd0));
                        chk("last", last, (e.a == 7'(N - 1)));
                    end
                end else begin
                    chk("first_idle", first, 0);
                    chk("last_idle", last, 0);
                    if (q.size() > 0 && q[0].cyc <= cyc) begin
                        void'(q.pop_front());
                        chk("tap_missing", tap_vld, 1);
                    end
                end
            end
        end
    end

    initial begin
        int c0;
        int nx;
        logic r;
        logic s;
        n_chk = 0; n_pass = 0; cyc = 0; last_acc = -1000; m_ovr = 1'b0;
        for (int i = 0; i < 128; i++) begin
            srl[i] = 16'h0;
            hist.push_back(16'h0);
        end
        for (int i = 0; i < MAXC; i++) begin
            exp_ce[i] = 0; exp_busy[i] = 0; exp_ovr[i] = 0;
            exp_sra[i] = 7'd0; exp_d[i] = 16'h0;
        end
        rst = 1'b1; in_stb = 1'b0; din = 16'h0; ovr_clr = 1'b0;
        model(0, 1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'h5555, 1'b0);   // strobe coincident with reset
        idle(2);

        // Five samples, each strobed in the FLUSH cycle of the previous sweep.
        for (int v = 1; v <= 5; v++) begin
            step(1'b0, 1'b1, 16'(v), 1'b0);
            idle(N + 1);
        end
        idle(12);

        // Strobe while sr_a = 3: dropped, overrun reported.
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        idle(4);
        step(1'b0, 1'b1, 16'hDEAD, 1'b0);
        idle(12);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        idle(3);

        // Reset while sr_a = 5, then a fresh full sweep.
        step(1'b0, 1'b1, 16'hBEEF, 1'b0);
        idle(6);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        idle(2);
        step(1'b0, 1'b1, 16'hCAFE, 1'b0);
        idle(N + 6);

        // Randomised traffic. Reset is never placed on the LOAD cycle, where
        // the delay line is shifting.
        c0 = cyc;
        while (cyc < c0 + 1500) begin
            nx = cyc + 1;
            r  = ($urandom_range(99) == 0) && (nx != last_acc + 1);
            if (nx == last_acc + N + 2) s = ($urandom_range(1) == 1);
            else                        s = ($urandom_range(4) == 0);
            step(r, s, 16'($urandom), ($urandom_range(7) == 0));
        end
        idle(N + 12);

        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
